// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient stage: pops gray pixels, pushes clamped |Gx|+|Gy|/2 in raster order.
// A 2*WIDTH+3 pixel shift register supplies the window; border outputs are forced to zero.
module sobel_filter #(
    parameter int WIDTH    = 720,
    parameter int HEIGHT   = 540,
    parameter int REG_SIZE = 2*WIDTH+3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_empty,
    output logic       in_rd_en,
    input  logic [7:0] in_dout,
    input  logic       out_full,
    output logic       out_wr_en,
    output logic [7:0] out_din
);
    localparam int NPIX = WIDTH*HEIGHT;
    localparam int CW   = $clog2(NPIX+1);
    localparam int RW   = $clog2(HEIGHT+1);
    localparam int XW   = $clog2(WIDTH+1);
    localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH);
    localparam logic [CW-1:0] RUN_LAST  = CW'(NPIX-1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT-1);
    localparam logic [XW-1:0] COL_LAST  = XW'(WIDTH-1);

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t        r_state;
    logic [CW-1:0] r_in_cnt;
    logic [RW-1:0] r_out_row;
    logic [XW-1:0] r_out_col;
    logic [7:0]    r_sr [REG_SIZE];

    logic               w_rd;
    logic               w_wr;
    logic               w_step;
    logic [7:0]         w_x;
    logic [9:0]         w_right;
    logic [9:0]         w_left;
    logic [9:0]         w_bot;
    logic [9:0]         w_top;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [10:0]        w_ax;
    logic [10:0]        w_ay;
    logic [11:0]        w_sum;
    logic [10:0]        w_mag;
    logic               w_border;

    // Handshake decode; everything is held off while reset is asserted.
    always_comb begin
        w_rd = 1'b0;
        w_wr = 1'b0;
        case (r_state)
            S_FILL:  w_rd = !in_empty;
            S_RUN: begin
                w_rd = !in_empty && !out_full;
                w_wr = w_rd;
            end
            S_FLUSH: w_wr = !out_full;
            default: ;
        endcase
        if (!reset) begin
            w_rd = 1'b0;
            w_wr = 1'b0;
        end
    end

    assign w_step    = w_rd || w_wr;
    assign in_rd_en  = w_rd;
    assign out_wr_en = w_wr;
    assign w_x       = (r_state == S_FLUSH) ? 8'd0 : in_dout;

    // Window columns/rows weighted 1,2,1; x is the bottom-right neighbour of the output center.
    assign w_right = {2'b00, w_x} + {1'b0, r_sr[WIDTH-1], 1'b0} + {2'b00, r_sr[2*WIDTH-1]};
    assign w_left  = {2'b00, r_sr[1]} + {1'b0, r_sr[WIDTH+1], 1'b0} + {2'b00, r_sr[2*WIDTH+1]};
    assign w_bot   = {2'b00, w_x} + {1'b0, r_sr[0], 1'b0} + {2'b00, r_sr[1]};
    assign w_top   = {2'b00, r_sr[2*WIDTH-1]} + {1'b0, r_sr[2*WIDTH], 1'b0} + {2'b00, r_sr[2*WIDTH+1]};

    assign w_gx  = $signed({1'b0, w_right}) - $signed({1'b0, w_left});
    assign w_gy  = $signed({1'b0, w_bot}) - $signed({1'b0, w_top});
    assign w_ax  = w_gx[10] ? $unsigned(11'(-w_gx)) : $unsigned(w_gx);
    assign w_ay  = w_gy[10] ? $unsigned(11'(-w_gy)) : $unsigned(w_gy);
    assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};
    assign w_mag = 11'(w_sum >> 1);

    assign w_border = (r_out_row == '0) || (r_out_row == ROW_LAST) ||
                      (r_out_col == '0) || (r_out_col == COL_LAST);

    always_comb begin
        out_din = (w_mag > 11'd255) ? 8'hFF : w_mag[7:0];
        if (!reset || w_border) begin
            out_din = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_SIZE; i++) begin
                r_sr[i] <= 8'd0;
            end
        end else if (w_step) begin
            r_sr[0] <= w_x;
            for (int i = 1; i < REG_SIZE; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_FILL;
            r_in_cnt  <= '0;
            r_out_row <= '0;
            r_out_col <= '0;
        end else if (w_step) begin
            if (w_rd) begin
                r_in_cnt <= r_in_cnt + CW'(1);
            end
            if (w_wr) begin
                if (r_out_col == COL_LAST) begin
                    r_out_col <= '0;
                    r_out_row <= r_out_row + RW'(1);
                end else begin
                    r_out_col <= r_out_col + XW'(1);
                end
            end
            case (r_state)
                S_FILL:  if (r_in_cnt == FILL_LAST) r_state <= S_RUN;
                S_RUN:   if (r_in_cnt == RUN_LAST) r_state <= S_FLUSH;
                S_FLUSH: begin
                    // Last border write of the frame: rearm for the next frame with no idle cycle.
                    if (r_out_row == ROW_LAST && r_out_col == COL_LAST) begin
                        r_state   <= S_FILL;
                        r_in_cnt  <= '0;
                        r_out_row <= '0;
                        r_out_col <= '0;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_filter.sv
// Directed bench for sobel_filter on a 4x3 image: hand-computed frames, stalls, back-to-back and mid-frame reset.
module tb_sobel_filter;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int NP   = W*H;
    localparam int MAXF = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_empty;
    logic       in_rd_en;
    logic [7:0] in_dout;
    logic       out_full;
    logic       out_wr_en;
    logic [7:0] out_din;

    always #5 clock = ~clock;

    sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] img     [0:NP*MAXF-1];
    logic [7:0] got     [0:NP*MAXF-1];
    int         exp_out [0:NP*MAXF-1];
    int rd_idx, wr_cnt, cyc, first_rd, last_wr, viol;

    task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got_v, exp_v);
        end
    endtask

    function automatic int px(input int base, input int r, input int c);
        return int'(img[base + r*W + c]);
    endfunction

    // Plain 2-D Sobel over the stored image, used for the random frames.
    function automatic int sobel_ref(input int base, input int r, input int c);
        int gx, gy, mag;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        gx = (px(base,r-1,c+1) + 2*px(base,r,c+1) + px(base,r+1,c+1))
           - (px(base,r-1,c-1) + 2*px(base,r,c-1) + px(base,r+1,c-1));
        gy = (px(base,r+1,c-1) + 2*px(base,r+1,c) + px(base,r+1,c+1))
           - (px(base,r-1,c-1) + 2*px(base,r-1,c) + px(base,r-1,c+1));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = (gx + gy) >> 1;
        return (mag > 255) ? 255 : mag;
    endfunction

    // Feeds img[0..npix-1], collects writes until nwr outputs, stop_rd reads, or the cycle budget.
    task automatic run_stream(input int npix, input int nwr, input bit stall, input int stop_rd);
        rd_idx = 0; wr_cnt = 0; cyc = 0; first_rd = -1; last_wr = -1;
        while (wr_cnt < nwr && rd_idx < stop_rd && cyc < 2000) begin
            in_dout  = (rd_idx < npix) ? img[rd_idx] : 8'd0;
            in_empty = (rd_idx >= npix) || (stall && ($urandom_range(0, 99) < 30));
            out_full = stall && ((cyc % 37) < 5);
            @(negedge clock);
            if (out_wr_en && out_full) viol++;
            if (in_rd_en && in_empty) viol++;
            if (in_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                rd_idx++;
            end
            if (out_wr_en) begin
                got[wr_cnt] = out_din;
                last_wr     = cyc;
                wr_cnt++;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        in_empty = 1'b1;
        out_full = 1'b0;
    endtask

    task automatic compare_outputs(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp_out[i]));
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < NP*MAXF; i++) exp_out[i] = 0;
    endtask

    initial begin
        reset = 1'b0; in_empty = 1'b0; out_full = 1'b0; in_dout = 8'd0; viol = 0;
        @(negedge clock);
        check_val("rst_rd_en", 32'(in_rd_en), 32'd0);
        check_val("rst_wr_en", 32'(out_wr_en), 32'd0);
        check_val("rst_din", 32'(out_din), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1; in_empty = 1'b1;
        @(posedge clock); #1;

        // Flat image: every output is zero; 17 cycles first read to last write.
        for (int i = 0; i < NP; i++) img[i] = 8'd100;
        clear_exp();
        run_stream(NP, NP, 1'b0, NP+1);
        check_val("flat_writes", 32'(wr_cnt), 32'(NP));
        check_val("flat_span", 32'(last_wr - first_rd + 1), 32'd17);
        compare_outputs("flat", NP);

        // Vertical edge: right half 20 gives Gx=80 at both interior pixels.
        for (int i = 0; i < NP; i++) img[i] = ((i % W) >= 2) ? 8'd20 : 8'd0;
        clear_exp(); exp_out[5] = 40; exp_out[6] = 40;
        run_stream(NP, NP, 1'b0, NP+1);
        check_val("edge_writes", 32'(wr_cnt), 32'(NP));
        compare_outputs("edge", NP);

        // Single bright pixel at (0,2): top-right of (1,1), top-centre of (1,2).
        for (int i = 0; i < NP; i++) img[i] = 8'd0;
        img[2] = 8'd255;
        clear_exp(); exp_out[5] = 255; exp_out[6] = 255;
        run_stream(NP, NP, 1'b0, NP+1);
        compare_outputs("dot", NP);

        // Left half 255: Gx=-1020, magnitude clamps to 255.
        for (int i = 0; i < NP; i++) img[i] = ((i % W) < 2) ? 8'd255 : 8'd0;
        clear_exp(); exp_out[5] = 255; exp_out[6] = 255;
        run_stream(NP, NP, 1'b0, NP+1);
        compare_outputs("sat", NP);

        // Ramp 10*c+3*r: Gx=80, Gy=24, mag=52.
        for (int i = 0; i < NP; i++) img[i] = 8'(10*(i % W) + 3*(i / W));
        clear_exp(); exp_out[5] = 52; exp_out[6] = 52;
        run_stream(NP, NP, 1'b0, NP+1);
        compare_outputs("ramp", NP);

        // Two back-to-back frames: identical outputs and no idle cycle between them.
        for (int i = 0; i < 2*NP; i++) img[i] = ((i % W) >= 2) ? 8'd20 : 8'd0;
        clear_exp();
        exp_out[5] = 40; exp_out[6] = 40; exp_out[NP+5] = 40; exp_out[NP+6] = 40;
        run_stream(2*NP, 2*NP, 1'b0, 2*NP+1);
        check_val("b2b_writes", 32'(wr_cnt), 32'(2*NP));
        check_val("b2b_span", 32'(last_wr - first_rd + 1), 32'd34);
        compare_outputs("b2b", 2*NP);

        // Random frames with out_full bursts and random in_empty.
        for (int i = 0; i < 6*NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int f = 0; f < 6; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    exp_out[f*NP + r*W + c] = sobel_ref(f*NP, r, c);
        viol = 0;
        run_stream(6*NP, 6*NP, 1'b1, 6*NP+1);
        check_val("stall_writes", 32'(wr_cnt), 32'(6*NP));
        check_val("stall_viol", 32'(viol), 32'd0);
        compare_outputs("stall", 6*NP);

        // Mid-frame reset after 5 reads, then a fresh frame.
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        run_stream(NP, NP, 1'b0, 5);
        reset = 1'b0; in_empty = 1'b0; out_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            check_val($sformatf("mid_rst_rd_en%0d", k), 32'(in_rd_en), 32'd0);
            check_val($sformatf("mid_rst_wr_en%0d", k), 32'(out_wr_en), 32'd0);
            check_val($sformatf("mid_rst_din%0d", k), 32'(out_din), 32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b1; in_empty = 1'b1;
        for (int i = 0; i < NP; i++) img[i] = 8'($urandom_range(0, 255));
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                exp_out[r*W + c] = sobel_ref(0, r, c);
        run_stream(NP, NP, 1'b0, NP+1);
        check_val("post_rst_writes", 32'(wr_cnt), 32'(NP));
        check_val("post_rst_span", 32'(last_wr - first_rd + 1), 32'd17);
        compare_outputs("post_rst", NP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
